// File: rtl/ps2_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ps2_cmd_pkg
// Brief   : Scan codes, command encodings and parser states for ps2_cmd_sequencer
// Revision: 1.0
// ============================================================================
package ps2_cmd_pkg;

    localparam logic [7:0] SC_H     = 8'h33;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BAT   = 8'hAA;

    localparam logic [1:0] CMD_HIT   = 2'd0;
    localparam logic [1:0] CMD_STAND = 2'd1;
    localparam logic [1:0] CMD_DEAL  = 2'd2;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_BREAK     = 2'd1;
    localparam logic [1:0] ST_EXT       = 2'd2;
    localparam logic [1:0] ST_EXT_BREAK = 2'd3;

    typedef struct packed {
        logic       mapped;
        logic [1:0] code;
        logic [2:0] onehot;   // {D,S,H}, matches held_keys / accept_mask layout
    } key_lookup_t;

    function automatic key_lookup_t lookup_key(input logic [7:0] b);
        key_lookup_t k;
        k = '{mapped: 1'b0, code: CMD_HIT, onehot: 3'b000};
        case (b)
            SC_H:    k = '{mapped: 1'b1, code: CMD_HIT,   onehot: 3'b001};
            SC_S:    k = '{mapped: 1'b1, code: CMD_STAND, onehot: 3'b010};
            SC_D:    k = '{mapped: 1'b1, code: CMD_DEAL,  onehot: 3'b100};
            default: k = '{mapped: 1'b0, code: CMD_HIT,   onehot: 3'b000};
        endcase
        return k;
    endfunction

    function automatic logic is_protocol_byte(input logic [7:0] b);
        logic r;
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: r = 1'b1;
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module  : cmd_fifo
// Brief   : Synchronous FIFO with push/pop/flush; head is read combinationally
// Revision: 1.0
// ============================================================================
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      cnt;
    logic             do_pop;
    logic             do_push;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign head    = mem[rd_ptr];
    assign count   = cnt;
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO may still accept
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ps2_cmd_sequencer
// Brief   : PS/2 set-2 parser with typematic suppression, phase mask and cmd queue
// Revision: 1.0
// ============================================================================
module ps2_cmd_sequencer
    import ps2_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int PREFIX_TIMEOUT = 100000
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic [7:0]                    ps2_data,
    input  logic                          ps2_data_en,
    input  logic [2:0]                    accept_mask,
    input  logic                          flush,
    input  logic                          cmd_ready,
    output logic                          cmd_valid,
    output logic [1:0]                    cmd_code,
    output logic [2:0]                    held_keys,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(PREFIX_TIMEOUT + 1);

    logic [1:0]    state;
    logic [CW-1:0] tmo_cnt;
    logic [2:0]    held;
    logic          ovf;

    key_lookup_t   key;
    logic          proto;
    logic          make_evt;
    logic          fresh_make;
    logic          want_push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;

    assign key        = lookup_key(ps2_data);
    assign proto      = is_protocol_byte(ps2_data);
    assign make_evt   = ps2_data_en && !proto && (state == ST_IDLE) && key.mapped;
    // A key already held is a typematic repeat and never re-fires
    assign fresh_make = make_evt && ((held & key.onehot) == 3'b000);
    assign want_push  = fresh_make && ((accept_mask & key.onehot) != 3'b000);
    assign pop        = cmd_valid && cmd_ready;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= ST_IDLE;
            tmo_cnt <= '0;
            held    <= 3'b000;
            ovf     <= 1'b0;
        end else begin
            if (want_push && fifo_full && !pop && !flush) begin
                ovf <= 1'b1;
            end

            if (ps2_data_en) begin
                tmo_cnt <= '0;
                if (proto) begin
                    state <= ST_IDLE;
                    if (ps2_data == SC_BAT) begin
                        held <= 3'b000;
                    end
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (ps2_data == SC_BREAK) begin
                                state <= ST_BREAK;
                            end else if (ps2_data == SC_EXT) begin
                                state <= ST_EXT;
                            end else if (fresh_make) begin
                                held <= held | key.onehot;
                            end
                        end
                        ST_BREAK: begin
                            held  <= held & ~key.onehot;
                            state <= ST_IDLE;
                        end
                        ST_EXT: begin
                            state <= (ps2_data == SC_BREAK) ? ST_EXT_BREAK : ST_IDLE;
                        end
                        default: begin
                            state <= ST_IDLE;
                        end
                    endcase
                end
            end else if (state != ST_IDLE) begin
                // Abandon a dangling prefix after PREFIX_TIMEOUT quiet cycles
                if (tmo_cnt == CW'(PREFIX_TIMEOUT - 1)) begin
                    state   <= ST_IDLE;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clk       (CLOCK_50),
        .rst       (reset),
        .push      (want_push),
        .push_data (key.code),
        .pop       (cmd_ready),
        .flush     (flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (cmd_code),
        .count     (fifo_count)
    );

    assign cmd_valid = !fifo_empty;
    assign held_keys = held;
    assign overflow  = ovf;

endmodule
`default_nettype wire

// File: tb/tb_ps2_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_ps2_cmd_sequencer
// Brief   : Directed + random bench for ps2_cmd_sequencer against a queue model
// Revision: 1.0
// ============================================================================
module tb_ps2_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 50;

    logic       CLOCK_50;
    logic       reset;
    logic [7:0] ps2_data;
    logic       ps2_data_en;
    logic [2:0] accept_mask;
    logic       flush;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic [2:0] held_keys;
    logic       overflow;
    logic [2:0] fifo_count;

    ps2_cmd_sequencer #(
        .FIFO_DEPTH     (DEPTH),
        .PREFIX_TIMEOUT (TMO)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .ps2_data    (ps2_data),
        .ps2_data_en (ps2_data_en),
        .accept_mask (accept_mask),
        .flush       (flush),
        .cmd_ready   (cmd_ready),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .held_keys   (held_keys),
        .overflow    (overflow),
        .fifo_count  (fifo_count)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    // Reference model: pending prefix as text-like tag, queue of commands
    typedef enum int {P_NONE, P_BRK, P_EXT, P_EXTBRK} prefix_e;
    prefix_e    m_prefix;
    int         m_idle;
    logic [2:0] m_held;
    logic       m_ovf;
    logic [1:0] q[$];

    int tests = 0;
    int fails = 0;

    function automatic int key_index(input logic [7:0] b);
        if (b == 8'h33) return 0;
        if (b == 8'h1B) return 1;
        if (b == 8'h23) return 2;
        return -1;
    endfunction

    function automatic bit is_proto(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFA) ||
               (b == 8'hFC) || (b == 8'hFD) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prefix = P_NONE;
        m_idle   = 0;
        m_held   = 3'b000;
        m_ovf    = 1'b0;
        q.delete();
    endtask

    task automatic model_step(input bit en, input logic [7:0] b);
        bit         do_push;
        bit         do_pop;
        logic [1:0] code;
        int         k;
        do_push = 0;
        code    = 2'd0;
        do_pop  = (q.size() > 0) && cmd_ready;
        k       = key_index(b);
        if (en) begin
            m_idle = 0;
            if (is_proto(b)) begin
                if (b == 8'hAA) m_held = 3'b000;
                m_prefix = P_NONE;
            end else begin
                case (m_prefix)
                    P_NONE: begin
                        if (b == 8'hF0) m_prefix = P_BRK;
                        else if (b == 8'hE0) m_prefix = P_EXT;
                        else if (k >= 0 && !m_held[k]) begin
                            m_held[k] = 1'b1;
                            if (accept_mask[k]) begin
                                do_push = 1;
                                code    = 2'(k);
                            end
                        end
                    end
                    P_BRK: begin
                        if (k >= 0) m_held[k] = 1'b0;
                        m_prefix = P_NONE;
                    end
                    P_EXT:   m_prefix = (b == 8'hF0) ? P_EXTBRK : P_NONE;
                    default: m_prefix = P_NONE;
                endcase
            end
        end else if (m_prefix != P_NONE) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_prefix = P_NONE;
                m_idle   = 0;
            end
        end
        if (flush) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                if (q.size() < DEPTH) q.push_back(code);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check("cmd_valid", cmd_valid, (q.size() > 0));
        if (q.size() > 0) check("cmd_code", cmd_code, q[0]);
        check("fifo_count", fifo_count, q.size());
        check("held_keys", held_keys, m_held);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic step(input bit en, input logic [7:0] b);
        ps2_data_en = en;
        ps2_data    = b;
        @(posedge CLOCK_50);
        model_step(en, b);
        #1;
        ps2_data_en = 1'b0;
        flush       = 1'b0;
        compare_all();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        ps2_data_en = 1'b0;
        flush       = 1'b0;
        @(posedge CLOCK_50);
        model_reset();
        #1;
        reset = 1'b0;
        compare_all();
        check("reset_code", cmd_code, 2'd0);
    endtask

    task automatic press_release(input logic [7:0] b);
        step(1, b);
        step(1, 8'hF0);
        step(1, b);
    endtask

    task automatic drain();
        cmd_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) step(0, 8'h00);
        cmd_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] pool [10];
        int         r;
        pool = '{8'h33, 8'h1B, 8'h23, 8'hF0, 8'hF0, 8'hE0, 8'hAA, 8'hFA, 8'h1C, 8'h00};

        reset       = 1'b1;
        ps2_data    = 8'h00;
        ps2_data_en = 1'b0;
        accept_mask = 3'b111;
        flush       = 1'b0;
        cmd_ready   = 1'b0;
        model_reset();
        do_reset();
        check("reset_valid", cmd_valid, 1'b0);

        // 1: single make gives HIT next cycle; release queues nothing
        step(1, 8'h33);
        check("t1_valid", cmd_valid, 1'b1);
        check("t1_code", cmd_code, 2'd0);
        step(1, 8'hF0);
        step(1, 8'h33);
        check("t1_count", fifo_count, 3'd1);
        check("t1_held", held_keys, 3'b000);
        drain();

        // 2: typematic repeats suppressed
        step(1, 8'h33); step(1, 8'h33); step(1, 8'h33);
        step(1, 8'hF0); step(1, 8'h33);
        step(1, 8'h33);
        check("t2_count", fifo_count, 3'd2);
        press_release(8'h1C);
        step(1, 8'hF0); step(1, 8'h33);
        drain();

        // 3: masked key stays held and never fires late
        accept_mask = 3'b001;
        step(1, 8'h23);
        step(1, 8'hF0); step(1, 8'h23);
        accept_mask = 3'b111;
        step(0, 8'h00);
        check("t3_empty", cmd_valid, 1'b0);
        step(1, 8'h23);
        check("t3_deal", cmd_code, 2'd2);
        step(1, 8'hF0); step(1, 8'h23);
        drain();

        // 4: overflow at depth, then push+pop while full
        press_release(8'h33); press_release(8'h1B); press_release(8'h23);
        press_release(8'h33); press_release(8'h1B);
        check("t4_count", fifo_count, 3'd4);
        check("t4_ovf", overflow, 1'b1);
        check("t4_head", cmd_code, 2'd0);
        cmd_ready = 1'b1;
        step(1, 8'h33);
        check("t4_full_count", fifo_count, 3'd4);
        check("t4_full_ovf", overflow, 1'b1);
        check("t4_head2", cmd_code, 2'd1);
        step(0, 8'h00);
        check("t4_head3", cmd_code, 2'd2);
        cmd_ready = 1'b0;
        step(1, 8'hF0); step(1, 8'h33);
        drain();

        // 5: extended make discarded; prefix timeout
        step(1, 8'hE0); step(1, 8'h33);
        check("t5_ext_count", fifo_count, 3'd0);
        check("t5_ext_held", held_keys, 3'b000);
        step(1, 8'hF0);
        for (int i = 0; i < TMO; i++) step(0, 8'h00);
        step(1, 8'h33);
        check("t5_tmo_hit", fifo_count, 3'd1);
        step(1, 8'hF0); step(1, 8'h33);
        drain();

        // 6: flush with simultaneous push, BAT, reset mid-prefix
        step(1, 8'h33); step(1, 8'h1B);
        check("t6_two", fifo_count, 3'd2);
        flush = 1'b1;
        step(1, 8'h23);
        check("t6_flush_count", fifo_count, 3'd0);
        check("t6_flush_valid", cmd_valid, 1'b0);
        step(1, 8'hAA);
        check("t6_bat", held_keys, 3'b000);
        step(1, 8'hF0);
        do_reset();
        step(1, 8'h33);
        check("t6_after_reset", cmd_code, 2'd0);
        check("t6_after_reset_cnt", fifo_count, 3'd1);

        // Random traffic
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 29) == 0) accept_mask = 3'($urandom_range(0, 7));
            cmd_ready = ($urandom_range(0, 2) == 0);
            flush     = ($urandom_range(0, 59) == 0);
            r = $urandom_range(0, 99);
            if (r < 2) begin
                for (int g = 0; g < TMO - 3 + int'($urandom_range(0, 6)); g++) step(0, 8'h00);
            end else if (r < 55) begin
                step(1, pool[$urandom_range(0, 9)]);
            end else begin
                step(0, 8'h00);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
